p2p_matrix_mult_stream: RTL and testbench

Parametrised successor to the fixed 8-bit point-to-point (element-wise) matrix multiplier. It accepts matrix A and then matrix B as one element per beat on a shared input bus, and computes C[i] = A[i] × B[i] at full product width with a per-element overflow flag. It returns C over a valid/ready output stream and pulses `done` at the end. It sits between the element-stream source and any downstream consumer that can apply backpressure.

---
 rtl/p2p_matrix_mult_stream_pkg.sv | 10 +
 rtl/p2p_matrix_mult_stream_if.sv | 17 +
 rtl/p2p_matrix_mult_stream_mult_stage.sv | 20 ++
 rtl/p2p_matrix_mult_stream.sv | 67 ++++++
 tb/tb_p2p_matrix_mult_stream.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/p2p_matrix_mult_stream_pkg.sv
// p2p_pkg: shared state encoding and width helper for the point-to-point multipliers.
package p2p_pkg;
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, OUT, DONE} state_t;

    function automatic int clog2(input int n);
        int r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction
endpackage

// File: rtl/p2p_matrix_mult_stream_if.sv
// p2p_matrix_mult_stream_if: element input stream, product output stream and status.
interface p2p_matrix_mult_stream_if #(parameter int DATA_W = 8);
    logic                  start;
    logic [DATA_W-1:0]     a_in;
    logic                  a_valid;
    logic [2*DATA_W-1:0]   cout;
    logic                  cout_ovf;
    logic                  cout_valid;
    logic                  cout_ready;
    logic                  busy;
    logic                  done;

    modport master(output start, a_in, a_valid, cout_ready,
                   input cout, cout_ovf, cout_valid, busy, done);
    modport slave(input start, a_in, a_valid, cout_ready,
                  output cout, cout_ovf, cout_valid, busy, done);
endinterface

// File: rtl/p2p_matrix_mult_stream_mult_stage.sv
// p2p_mult_stage: full-width DATA_W x DATA_W multiply with narrow-result overflow flag.
module p2p_mult_stage #(
    parameter int DATA_W = 8,
    parameter int SIGNED = 0
) (
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    output logic [2*DATA_W-1:0] o_prod,
    output logic                o_ovf
);
    logic [2*DATA_W-1:0] w_a, w_b;
    logic [DATA_W:0]     w_hi;

    // Sign-extending to full width lets one modular multiply serve both modes.
    assign w_a    = {{DATA_W{(SIGNED != 0) && i_a[DATA_W-1]}}, i_a};
    assign w_b    = {{DATA_W{(SIGNED != 0) && i_b[DATA_W-1]}}, i_b};
    assign o_prod = w_a * w_b;
    assign w_hi   = o_prod[2*DATA_W-1:DATA_W-1];
    assign o_ovf  = (SIGNED != 0) ? !(&w_hi || !(|w_hi)) : |w_hi[DATA_W:1];
endmodule

// File: rtl/p2p_matrix_mult_stream.sv
// p2p_matrix_mult_stream: streams in A then B, returns element-wise products C over valid/ready.
module p2p_matrix_mult_stream
    import p2p_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ROWS   = 4,
    parameter int COLS   = 2,
    parameter int SIGNED = 0
) (
    input logic clk,
    input logic rst,
    p2p_matrix_mult_stream_if.slave bus
);
    localparam int N  = ROWS * COLS;
    localparam int IW = clog2(N);

    state_t              r_state, w_next;
    logic [IW-1:0]       r_idx;
    logic [DATA_W-1:0]   r_buf_a [N];
    logic [2*DATA_W:0]   r_buf_c [N];
    logic [2*DATA_W-1:0] w_prod;
    logic                w_ovf, w_last, w_beat, w_acc;

    assign w_last = r_idx == IW'(N - 1);
    assign w_beat = bus.a_valid && (r_state == LOAD_A || r_state == LOAD_B);
    assign w_acc  = bus.cout_ready && r_state == OUT;

    p2p_mult_stage #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_mult (
        .i_a    (r_buf_a[r_idx]),
        .i_b    (bus.a_in),
        .o_prod (w_prod),
        .o_ovf  (w_ovf)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? LOAD_A : IDLE;
            LOAD_A:  w_next = (w_beat && w_last) ? LOAD_B : LOAD_A;
            LOAD_B:  w_next = (w_beat && w_last) ? OUT : LOAD_B;
            OUT:     w_next = (w_acc && w_last) ? DONE : OUT;
            default: w_next = IDLE;
        endcase
    end

    // idx restarts on every state change, so each phase begins at element 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) r_idx <= '0;
            else if (w_beat || w_acc) r_idx <= r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == LOAD_A && bus.a_valid) r_buf_a[r_idx] <= bus.a_in;
        if (r_state == LOAD_B && bus.a_valid) r_buf_c[r_idx] <= {w_ovf, w_prod};
    end

    assign bus.cout_valid             = r_state == OUT;
    assign {bus.cout_ovf, bus.cout}   = bus.cout_valid ? r_buf_c[r_idx] : '0;
    assign bus.busy                   = r_state != IDLE;
    assign bus.done                   = r_state == DONE;
endmodule

// File: tb/tb_p2p_matrix_mult_stream.sv
// tb_p2p_matrix_mult_stream: directed checks on default, signed N=4 and 3x3 instances.
module tb_p2p_matrix_mult_stream;
    typedef logic [7:0]  vec8_t [8];
    typedef logic [16:0] res8_t [8];

    logic clk = 0;
    logic rst = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   c0 = 0;
    int   t_done = 0;
    bit   hold_start = 0;

    vec8_t a1 = '{8'd12, 8'd13, 8'd112, 8'd143, 8'd12, 8'd1, 8'd11, 8'd17};
    vec8_t b1 = '{8'd13, 8'd18, 8'd10, 8'd15, 8'd16, 8'd17, 8'd33, 8'd23};
    res8_t e1 = '{{1'b0, 16'd156}, {1'b0, 16'd234}, {1'b1, 16'd1120}, {1'b1, 16'd2145},
                  {1'b0, 16'd192}, {1'b0, 16'd17}, {1'b1, 16'd363}, {1'b1, 16'd391}};
    vec8_t a2 = '{8'd255, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd255};
    vec8_t b2 = '{8'd255, 8'd7, 8'd255, 8'd128, 8'd85, 8'd64, 8'd51, 8'd1};
    res8_t e2 = '{{1'b1, 16'd65025}, {1'b0, 16'd0}, {1'b0, 16'd255}, {1'b1, 16'd256},
                  {1'b0, 16'd255}, {1'b1, 16'd256}, {1'b0, 16'd255}, {1'b0, 16'd255}};
    logic [7:0]  sa [4] = '{8'hFD, 8'h7F, 8'h80, 8'h02};
    logic [7:0]  sb [4] = '{8'h05, 8'h02, 8'h80, 8'hC0};
    logic [16:0] se [4] = '{{1'b0, 16'hFFF1}, {1'b1, 16'h00FE}, {1'b1, 16'h4000}, {1'b0, 16'hFF80}};
    logic [7:0]  qa [9] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd200};
    logic [7:0]  qb [9] = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd200};
    logic [16:0] qe [9] = '{17'd10, 17'd22, 17'd36, 17'd52, 17'd70, 17'd90, 17'd112, 17'd136,
                            {1'b1, 16'd40000}};

    p2p_matrix_mult_stream_if #(.DATA_W(8)) m_if ();
    p2p_matrix_mult_stream_if #(.DATA_W(8)) s_if ();
    p2p_matrix_mult_stream_if #(.DATA_W(8)) q_if ();

    p2p_matrix_mult_stream u_m (.clk(clk), .rst(rst), .bus(m_if.slave));
    p2p_matrix_mult_stream #(.DATA_W(8), .ROWS(2), .COLS(2), .SIGNED(1)) u_s (.clk(clk), .rst(rst), .bus(s_if.slave));
    p2p_matrix_mult_stream #(.DATA_W(8), .ROWS(3), .COLS(3), .SIGNED(0)) u_q (.clk(clk), .rst(rst), .bus(q_if.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic begin_op();
        m_if.start = 1;
        c0 = cyc;
        @(negedge clk);
        m_if.start = hold_start;
        check("busy_load_a", m_if.busy, 1);
    endtask

    // Gaps also pulse start, which must be ignored while loading.
    task automatic load(input vec8_t v, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            while (gaps && $urandom_range(0, 2) == 0) begin
                m_if.a_valid = 0;
                m_if.a_in = 8'hAA;
                m_if.start = 1;
                @(negedge clk);
            end
            m_if.start = hold_start;
            m_if.a_in = v[i];
            m_if.a_valid = 1;
            @(negedge clk);
        end
        m_if.a_valid = 0;
        m_if.a_in = 8'h55;
    endtask

    task automatic collect(input res8_t e, input bit stalls, input string tag);
        int k = 0;
        int to = 0;
        bit st = 0;
        logic [16:0] held = '0;
        logic [16:0] cur;
        while (k < 8 && to < 300) begin
            cur = {m_if.cout_ovf, m_if.cout};
            if (m_if.cout_valid) begin
                if (st) check("stall_stable", cur, held);
                check(tag, cur, e[k]);
            end
            m_if.cout_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
            st = m_if.cout_valid && !m_if.cout_ready;
            held = cur;
            if (m_if.cout_valid && m_if.cout_ready) k++;
            @(negedge clk);
            to++;
        end
        m_if.cout_ready = 1;
        t_done = cyc;
        check("beat_count", k, 8);
        check("done_pulse", m_if.done, 1);
        check("valid_in_done", m_if.cout_valid, 0);
        @(negedge clk);
        check("done_one_cycle", m_if.done, 0);
        check("busy_after_done", m_if.busy, 0);
    endtask

    initial begin
        {m_if.start, m_if.a_in, m_if.a_valid, m_if.cout_ready} = '0;
        {s_if.start, s_if.a_in, s_if.a_valid, s_if.cout_ready} = '0;
        {q_if.start, q_if.a_in, q_if.a_valid, q_if.cout_ready} = '0;
        repeat (3) @(negedge clk);
        check("rst_cout", m_if.cout, 0);
        check("rst_ovf", m_if.cout_ovf, 0);
        check("rst_valid", m_if.cout_valid, 0);
        check("rst_busy", m_if.busy, 0);
        check("rst_done", m_if.done, 0);
        rst = 1;
        m_if.a_valid = 1;
        m_if.a_in = 8'hEE;
        repeat (2) @(negedge clk);
        check("idle_beats_ignored", m_if.busy, 0);
        m_if.a_valid = 0;

        begin_op();
        load(a1, 0);
        load(b1, 0);
        check("first_out_latency", m_if.cout_valid, 1);
        collect(e1, 0, "c_basic");
        check("op_length", t_done - c0 + 1, 26);

        begin_op();
        load(a1, 1);
        load(b1, 1);
        collect(e1, 1, "c_stall");

        hold_start = 1;
        begin_op();
        load(a1, 0);
        load(b1, 0);
        collect(e1, 0, "c_b2b_first");
        @(negedge clk);
        check("b2b_restart", m_if.busy, 1);
        load(a2, 0);
        load(b2, 0);
        hold_start = 0;
        m_if.start = 0;
        collect(e2, 0, "c_b2b_second");

        begin_op();
        load(a2, 0);
        m_if.a_valid = 1;
        m_if.a_in = b2[0];
        @(negedge clk);
        m_if.a_in = b2[1];
        @(negedge clk);
        m_if.a_in = b2[2];
        rst = 0;
        @(negedge clk);
        check("mid_rst_cout", m_if.cout, 0);
        check("mid_rst_ovf", m_if.cout_ovf, 0);
        check("mid_rst_valid", m_if.cout_valid, 0);
        check("mid_rst_busy", m_if.busy, 0);
        check("mid_rst_done", m_if.done, 0);
        rst = 1;
        m_if.a_valid = 0;
        @(negedge clk);
        check("post_rst_no_done", m_if.done, 0);
        check("post_rst_idle", m_if.busy, 0);
        begin_op();
        load(a2, 0);
        load(b2, 0);
        collect(e2, 0, "c_after_rst");

        s_if.start = 1;
        @(negedge clk);
        s_if.start = 0;
        s_if.a_valid = 1;
        for (int i = 0; i < 4; i++) begin s_if.a_in = sa[i]; @(negedge clk); end
        for (int i = 0; i < 4; i++) begin s_if.a_in = sb[i]; @(negedge clk); end
        s_if.a_valid = 0;
        s_if.cout_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check("c_signed", {s_if.cout_ovf, s_if.cout}, se[i]);
            @(negedge clk);
        end
        check("signed_done", s_if.done, 1);

        q_if.start = 1;
        @(negedge clk);
        q_if.start = 0;
        q_if.a_valid = 1;
        for (int i = 0; i < 9; i++) begin q_if.a_in = qa[i]; @(negedge clk); end
        for (int i = 0; i < 9; i++) begin q_if.a_in = qb[i]; @(negedge clk); end
        q_if.a_valid = 0;
        q_if.cout_ready = 1;
        for (int i = 0; i < 9; i++) begin
            check("c_n9_valid", q_if.cout_valid, 1);
            check("c_n9", {q_if.cout_ovf, q_if.cout}, qe[i]);
            @(negedge clk);
        end
        check("n9_no_extra_beat", q_if.cout_valid, 0);
        check("n9_done", q_if.done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
